// File: rtl/fft_bin_window.sv
// Purpose: passes the bins of each FFT frame that fall in a programmable window [start, end]
//          and tags every passed beat with its bin index; frames are checked against fft_last.
// Latency: 1 cycle; all outputs are registered. Backpressure: none, and a beat is never stalled.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   cfg_start_bin, cfg_end_bin    window bounds, sampled on the first beat of each frame
//   fft_data/fft_valid/fft_last   FFT output stream; fft_last marks bin FFT_N-1
//   out_data/out_valid/out_bin    passed sample with its bin index
//   out_last                      passed beat is the latched end bin
//   frame_err, err_count          framing error pulse and its saturating count
module fft_bin_window #(
  parameter int DATA_W = 32,
  parameter int FFT_N  = 1024,
  parameter int BIN_W  = $clog2(FFT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  cfg_start_bin,
  input  logic [BIN_W-1:0]  cfg_end_bin,
  input  logic [DATA_W-1:0] fft_data,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [BIN_W-1:0]  out_bin,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_N - 1);
  localparam logic [BIN_W-1:0] HALF_END = BIN_W'(FFT_N / 2 - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q;
  logic [BIN_W-1:0] cnt_q;
  logic [BIN_W-1:0] win_start_q;
  logic [BIN_W-1:0] win_end_q;

  logic [BIN_W-1:0] bin_d;
  logic [BIN_W-1:0] win_start_d;
  logic [BIN_W-1:0] win_end_d;
  logic             pass_d;
  logic             at_max_d;
  logic             frame_end_d;
  logic             err_d;

  // A beat seen in IDLE is bin 0 and uses the live cfg values, since this is
  // the same beat on which they get latched for the rest of the frame.
  always_comb begin
    bin_d       = (state_q == IDLE) ? '0 : cnt_q;
    win_start_d = (state_q == IDLE) ? cfg_start_bin : win_start_q;
    win_end_d   = (state_q == IDLE) ? cfg_end_bin   : win_end_q;
    pass_d      = fft_valid && (win_start_d <= bin_d) && (bin_d <= win_end_d);
    at_max_d    = (bin_d == LAST_BIN);
    // Either marker ends the frame; disagreement between them is a framing error
    // (short frame: fft_last early; long frame: counter hit the top without fft_last).
    frame_end_d = fft_last || at_max_d;
    err_d       = fft_valid && (fft_last != at_max_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_start_q <= '0;
      win_end_q   <= HALF_END;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_bin     <= '0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      out_valid <= pass_d;
      out_last  <= pass_d && (bin_d == win_end_d);
      frame_err <= err_d;
      // Data and bin tag hold on non-passed beats.
      if (pass_d) begin
        out_data <= fft_data;
        out_bin  <= bin_d;
      end
      if (err_d && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (fft_valid) begin
        win_start_q <= win_start_d;
        win_end_q   <= win_end_d;
        if (frame_end_d) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= RUN;
          cnt_q   <= bin_d + BIN_W'(1);
        end
      end
    end
  end

endmodule
